// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// State encoding is fixed here so the top level and any debug taps agree.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A-F) are clamped so a digit can never hold an illegal code.
  function automatic logic [3:0] bcd_sat(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for the BCD countdown timer.
// The master drives load/start/pause and the preset; the slave returns count and status.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  running;
  logic                  done;
  logic                  borrow_out;

  modport master (
    output load, load_value, start, pause,
    input  bcd_out, running, done, borrow_out
  );

  modport slave (
    input  load, load_value, start, pause,
    output bcd_out, running, done, borrow_out
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One MOD-10 down-counting BCD digit; borrow ripples to the next digit
// when a decrement hits an already-zero digit.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec_in,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       is_zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       digit <= BCD_ZERO;
    else if (load)   digit <= bcd_sat(load_digit);
    else if (dec_in) digit <= is_zero ? BCD_MAX : digit - 4'd1;
  end

  assign is_zero    = (digit == BCD_ZERO);
  assign borrow_out = dec_in && is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer: FSM plus prescaler driving a
// borrow chain of bcd_down_digit instances; pulses done on reaching zero.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  state_t                  state;
  logic [PW-1:0]           presc;
  logic                    done_q;
  logic [DIGITS-1:0][3:0]  digit;
  logic [DIGITS-1:0]       is_zero;
  logic [DIGITS:0]         dec;
  logic                    all_zero;
  logic                    last;
  logic                    tick;

  assign all_zero = &is_zero;
  // Count is exactly one: the tick that consumes it lands on zero.
  assign last     = (digit[0] == 4'd1) && (&(is_zero | DIGITS'(1)));
  // load and pause both outrank the decrement in the same cycle.
  assign tick     = (state == RUN) && !bus.load && !bus.pause && (presc == PRE_LAST);
  assign dec[0]   = tick;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_down_digit u_dig (
        .clk        (clk),
        .reset      (reset),
        .load       (bus.load),
        .load_digit (bus.load_value[4*i +: 4]),
        .dec_in     (dec[i]),
        .digit      (digit[i]),
        .borrow_out (dec[i+1]),
        .is_zero    (is_zero[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      presc  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state <= IDLE;
        presc <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (all_zero) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= RUN;
                presc <= '0;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state <= PAUSED;
            end else if (tick) begin
              presc <= '0;
              if (last) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          // Prescaler is left untouched so the partial period resumes.
          PAUSED:  if (bus.start) state <= RUN;
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.bcd_out    = digit;
  assign bus.running    = (state == RUN);
  assign bus.done       = done_q;
  assign bus.borrow_out = dec[DIGITS];

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (TICK_DIV 1 and 4) share one
// stimulus stream and are compared against a decimal-integer reference model.
module tb_bcd_countdown_timer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [15:0] lv = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(D)) b1 ();
  bcd_countdown_timer_if #(.DIGITS(D)) b4 ();

  assign b1.load = load;  assign b1.load_value = lv;  assign b1.start = start;  assign b1.pause = pause;
  assign b4.load = load;  assign b4.load_value = lv;  assign b4.start = start;  assign b4.pause = pause;

  bcd_countdown_timer #(.DIGITS(D), .TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  bcd_countdown_timer #(.DIGITS(D), .TICK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

  // Reference model: count held as a plain integer, state as 0..3.
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
  int m_st [2];
  int m_cnt[2];
  int m_pre[2];
  bit m_done[2];
  int td [2] = '{1, 4};

  function automatic int sat_val(input logic [15:0] x);
    int s = 0, m = 1;
    for (int i = 0; i < D; i++) begin
      logic [3:0] nib;
      nib = x[4*i +: 4];
      s += ((nib > 4'd9) ? 9 : int'(nib)) * m;
      m *= 10;
    end
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t /= 10;
    end
    return r;
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = S_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    m_done[k] = 1'b0;
    if (load) begin
      m_cnt[k] = sat_val(lv); m_st[k] = S_IDLE; m_pre[k] = 0;
    end else begin
      case (m_st[k])
        S_IDLE: if (start) begin
          if (m_cnt[k] == 0) begin m_st[k] = S_DONE; m_done[k] = 1'b1; end
          else begin m_st[k] = S_RUN; m_pre[k] = 0; end
        end
        S_RUN: begin
          if (pause) m_st[k] = S_PAUSED;
          else if (m_pre[k] == td[k] - 1) begin
            m_pre[k] = 0;
            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) begin m_st[k] = S_DONE; m_done[k] = 1'b1; end
          end else m_pre[k] = m_pre[k] + 1;
        end
        S_PAUSED: if (start) m_st[k] = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int k);
    logic [15:0] gb;
    logic gr, gd, gw;
    if (k == 0) begin gb = b1.bcd_out; gr = b1.running; gd = b1.done; gw = b1.borrow_out; end
    else        begin gb = b4.bcd_out; gr = b4.running; gd = b4.done; gw = b4.borrow_out; end
    chk($sformatf("dut%0d.bcd_out", td[k]),    int'(gb), int'(to_bcd(m_cnt[k])));
    chk($sformatf("dut%0d.running", td[k]),    int'(gr), int'(m_st[k] == S_RUN));
    chk($sformatf("dut%0d.done", td[k]),       int'(gd), int'(m_done[k]));
    chk($sformatf("dut%0d.borrow_out", td[k]), int'(gw), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset(k); else model_step(k);
    end
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic drive(input bit ld, input logic [15:0] v, input bit st, input bit ps);
    load = ld; lv = v; start = st; pause = ps;
  endtask

  typedef struct {
    bit          ld;
    logic [15:0] v;
    bit          st;
    bit          ps;
    logic [15:0] eb;
    bit          er;
    bit          ed;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int pulses;
    tbl[0]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0099, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0098, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 16'h00A5, 1'b0, 1'b0, 16'h0095, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 16'h0042, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0041, 1'b1, 1'b0};

    model_reset(0); model_reset(1);
    @(negedge clk);
    check_dut(0); check_dut(1);
    chk("reset.bcd_out", int'(b1.bcd_out), 0);
    reset = 1'b0;

    // Table vectors against constants (TICK_DIV=1 instance) and the model.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].ld, tbl[i].v, tbl[i].st, tbl[i].ps);
      cycle();
      chk($sformatf("vec%0d.bcd", i),  int'(b1.bcd_out), int'(tbl[i].eb));
      chk($sformatf("vec%0d.run", i),  int'(b1.running), int'(tbl[i].er));
      chk($sformatf("vec%0d.done", i), int'(b1.done),    int'(tbl[i].ed));
    end

    // Full run from 0100 to zero: exactly one done pulse, then hold at 0.
    drive(1'b1, 16'h0100, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (b1.done) pulses++;
    end
    chk("run100.done_pulses", pulses, 1);
    chk("run100.hold_zero", int'(b1.bcd_out), 0);
    drive(1'b0, 16'h0000, 1'b1, 1'b1); cycle();
    chk("done.start_pause_no_done", int'(b1.done), 0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0); cycle();
    chk("done.stays_zero", int'(b1.bcd_out), 0);
    drive(1'b1, 16'h0007, 1'b0, 1'b0); cycle();
    chk("done.reload", int'(b1.bcd_out), 16'h0007);
    chk("done.reload_run", int'(b1.running), 0);

    // Prescaler 4: two RUN cycles, pause five, resume; first tick after 4 RUN cycles.
    drive(1'b1, 16'h0002, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0); cycle(); cycle();
    chk("td4.pre_pause", int'(b4.bcd_out), 16'h0002);
    drive(1'b0, 16'h0000, 1'b0, 1'b1); cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("td4.frozen", int'(b4.bcd_out), 16'h0002);
      chk("td4.paused_run", int'(b4.running), 0);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0); cycle();
    chk("td4.third_run", int'(b4.bcd_out), 16'h0002);
    cycle();
    chk("td4.tick", int'(b4.bcd_out), 16'h0001);

    // Asynchronous reset between edges mid-count.
    drive(1'b1, 16'h0042, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("arst.pre", int'(b1.bcd_out), 16'h0042);
    #2 reset = 1'b1;
    #1;
    chk("arst.bcd", int'(b1.bcd_out), 0);
    chk("arst.run", int'(b1.running), 0);
    model_reset(0); model_reset(1);
    cycle();
    reset = 1'b0;
    cycle();
    chk("arst.no_done", int'(b1.done), 0);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] d0, d1, d2;
      d0 = 4'($urandom_range(0, 15));
      d1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      d2 = ($urandom_range(0, 20) == 0) ? 4'd1 : 4'd0;
      drive($urandom_range(0, 99) < 4, {4'd0, d2, d1, d0},
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1;
        chk("rnd.arst_bcd", int'(b4.bcd_out), 0);
        model_reset(0); model_reset(1);
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
